hazard_forward_unit: RTL



---
 rtl/hazard_forward_unit.sv | 74 +++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard of in-flight register writes driving operand
// forwarding, load-use stalls and a saturating stall counter for the decode stage.
module hazard_forward_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 7,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs,
    input  logic [REG_AW-1:0]       id_rt,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_we,
    input  logic [2:0]              id_avail,
    input  logic                    flush,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic                    stall,
    output logic                    fwd_rs_en,
    output logic [DATA_W-1:0]       fwd_rs_data,
    output logic                    fwd_rt_en,
    output logic [DATA_W-1:0]       fwd_rt_data,
    output logic [CNT_W-1:0]        stall_cnt
);
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [2:0]        avail;
    } entry_t;

    entry_t [DEPTH-1:0] sb_q, sb_d;
    logic   [CNT_W-1:0] cnt_q, cnt_d;
    logic               rs_nr, rt_nr;
    logic [2:0]         avail_c;

    // Result is {not_ready, forward_en, data}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [DATA_W+1:0] lookup(input logic [REG_AW-1:0] s,
                                                 input entry_t [DEPTH-1:0] sb,
                                                 input logic [DEPTH*DATA_W-1:0] sd);
        logic [DATA_W+1:0] r;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (sb[k].valid && sb[k].we && sb[k].rd == s)
                r = (k >= 32'(sb[k].avail)) ? {2'b01, sd[k*DATA_W +: DATA_W]} : {2'b10, {DATA_W{1'b0}}};
        return r;
    endfunction

    assign {rs_nr, fwd_rs_en, fwd_rs_data} = (id_valid && id_rs != '0) ? lookup(id_rs, sb_q, stage_data) : '0;
    assign {rt_nr, fwd_rt_en, fwd_rt_data} = (id_valid && id_rt != '0) ? lookup(id_rt, sb_q, stage_data) : '0;
    assign stall     = (rs_nr | rt_nr) & ~flush;
    assign stall_cnt = cnt_q;
    assign avail_c   = (32'(id_avail) >= DEPTH) ? 3'(DEPTH - 1) : id_avail;

    always_comb begin
        sb_d = {sb_q[DEPTH-2:0], entry_t'('0)};
        if (flush)
            sb_d[1].valid = 1'b0;
        if (id_valid && !flush && !stall)
            sb_d[0] = '{valid: 1'b1, we: id_we && id_rd != '0, rd: id_rd, avail: avail_c};
        cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
